// File: rtl/adam_axil_regs_pausable.sv
// AXI-Lite slave register bank with a pause_req/pause_ack responder; drains in-flight traffic before pausing.
// Define ADAM_AXIL_REGS_PROT_CHECK_EN to reject unprivileged (prot[0]=0) accesses with SLVERR.
module adam_axil_regs_pausable #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NO_REGS    = 8
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          pause_req,
  output logic                          pause_ack,

  input  logic [ADDR_WIDTH-1:0]         aw_addr,
  input  logic [2:0]                    aw_prot,
  input  logic                          aw_valid,
  output logic                          aw_ready,

  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic [DATA_WIDTH/8-1:0]       w_strb,
  input  logic                          w_valid,
  output logic                          w_ready,

  output logic [1:0]                    b_resp,
  output logic                          b_valid,
  input  logic                          b_ready,

  input  logic [ADDR_WIDTH-1:0]         ar_addr,
  input  logic [2:0]                    ar_prot,
  input  logic                          ar_valid,
  output logic                          ar_ready,

  output logic [DATA_WIDTH-1:0]         r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_valid,
  input  logic                          r_ready,

  output logic [NO_REGS*DATA_WIDTH-1:0] regs_q
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] NO_REGS_A = ADDR_WIDTH'(NO_REGS);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]            aw_prot_q, aw_prot_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs;
  logic wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
  logic [2:0]            wr_prot;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic wr_ok, rd_ok;

  // Acceptance gating: DRAIN only lets the missing half of a started write in.
  always_comb begin
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    ar_rdy = 1'b0;
    case (state_q)
      ST_RUN: begin
        aw_rdy = !aw_full_q;
        w_rdy  = !w_full_q;
        ar_rdy = !r_valid_q || r_ready;
      end
      ST_DRAIN: begin
        aw_rdy = !aw_full_q && w_full_q;
        w_rdy  = !w_full_q && aw_full_q;
      end
      default: ;
    endcase
  end

  assign aw_hs = aw_valid && aw_rdy;
  assign w_hs  = w_valid && w_rdy;
  assign ar_hs = ar_valid && ar_rdy;

  // Buffers are bypassed so an AW+W handshake can complete in the same cycle.
  assign wr_addr = aw_full_q ? aw_addr_q : aw_addr;
  assign wr_prot = aw_full_q ? aw_prot_q : aw_prot;
  assign wr_data = w_full_q ? w_data_q : w_data;
  assign wr_strb = w_full_q ? w_strb_q : w_strb;
  assign wr_fire = (aw_full_q || aw_hs) && (w_full_q || w_hs) && (!b_valid_q || b_ready);

  assign wr_idx = wr_addr >> ADDR_LSB;
  assign rd_idx = ar_addr >> ADDR_LSB;

`ifdef ADAM_AXIL_REGS_PROT_CHECK_EN
  assign wr_ok = (wr_idx < NO_REGS_A) && wr_prot[0];
  assign rd_ok = (rd_idx < NO_REGS_A) && ar_prot[0];
`else
  assign wr_ok = (wr_idx < NO_REGS_A);
  assign rd_ok = (rd_idx < NO_REGS_A);
`endif

  logic unused_prot;
  assign unused_prot = ^{wr_prot, ar_prot};

  // Register storage: one slice per register, byte-enabled update.
  for (genvar gi = 0; gi < NO_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr_fire && wr_ok && (wr_idx == ADDR_WIDTH'(gi))) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wr_strb[b]) reg_d[b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) reg_q <= '0;
      else      reg_q <= reg_d;
    end

    assign regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NO_REGS; k++) begin
      if (rd_idx == ADDR_WIDTH'(k)) rd_word = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pause FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED: if (!pause_req) state_d = ST_RUN;
      ST_RUN:    if (pause_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!pause_req)
          state_d = ST_RUN;
        else if (!aw_full_q && !w_full_q && !b_valid_q && !r_valid_q)
          state_d = ST_PAUSED;
      end
      default:   state_d = ST_PAUSED;
    endcase
  end

  // Buffer, response and read-data next state
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;

    if (wr_fire) begin
      aw_full_d = 1'b0;
    end else if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = aw_addr;
      aw_prot_d = aw_prot;
    end

    if (wr_fire) begin
      w_full_d = 1'b0;
    end else if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = w_data;
      w_strb_d = w_strb;
    end

    if (wr_fire) begin
      b_valid_d = 1'b1;
      b_resp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (b_ready) begin
      b_valid_d = 1'b0;
    end

    if (ar_hs) begin
      r_valid_d = 1'b1;
      r_data_d  = rd_ok ? rd_word : '0;
      r_resp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_PAUSED;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign pause_ack = (state_q == ST_PAUSED);
  assign aw_ready  = aw_rdy;
  assign w_ready   = w_rdy;
  assign ar_ready  = ar_rdy;
  assign b_valid   = b_valid_q;
  assign b_resp    = b_resp_q;
  assign r_valid   = r_valid_q;
  assign r_data    = r_data_q;
  assign r_resp    = r_resp_q;

endmodule
